// File: rtl/apb_mem_slave_if.sv
// APB bus bundle for apb_mem_slave: master drives address/control/write data,
// slave returns read data, ready and error strobes.
interface apb_mem_slave_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] PAddr;
    logic              PWrite;
    logic              PSel;
    logic              PEnable;
    logic [DATA_W-1:0] PWData;
    logic [DATA_W-1:0] PRData;
    logic              PReady;
    logic              PSlvErr;

    modport master (
        output PAddr, PWrite, PSel, PEnable, PWData,
        input  PRData, PReady, PSlvErr
    );

    modport slave (
        input  PAddr, PWrite, PSel, PEnable, PWData,
        output PRData, PReady, PSlvErr
    );
endinterface

// File: rtl/apb_mem_slave.sv
// APB word-addressed memory slave with programmable wait states, out-of-range
// error response and wrapping write/read success counters.
module apb_mem_slave #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           Rst,
    apb_mem_slave_if.slave bus,
    output logic [15:0]    wr_count,
    output logic [15:0]    rd_count
);
    localparam int         IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t            r_state;
    state_t            w_state;
    state_t            w_next;
    logic [3:0]        r_wait;
    logic              r_rd;
    logic              r_rd_err;
    logic [DATA_W-1:0] r_prdata;
    logic [15:0]       r_wr_count;
    logic [15:0]       r_rd_count;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_oob;
    logic [IDX_W-1:0]  w_idx;
    logic              w_wait_hit;
    logic              w_active;
    logic              w_done;
    logic              w_err;
    logic              w_mem_we;
    logic              w_rd_ok;
    logic              w_wait_inc;

    assign w_oob      = (32'(bus.PAddr) >= 32'(DEPTH));
    assign w_idx      = bus.PAddr[IDX_W-1:0];
    assign w_wait_hit = (r_wait == WS);
    assign w_active   = bus.PSel && bus.PEnable;

    // State register
    always_ff @(posedge clk) begin
        if (!Rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // SETUP is the cycle the master presents PSel=1/PEnable=0; it is decoded
    // from IDLE so a new transfer can follow a completion with no idle gap.
    always_comb begin
        w_state = r_state;
        if (r_state == S_IDLE && bus.PSel && !bus.PEnable) w_state = S_SETUP;
        w_next = S_IDLE;
        case (w_state)
            S_IDLE:   w_next = S_IDLE;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: w_next = (w_active && !w_wait_hit) ? S_ACCESS : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs and strobes
    always_comb begin
        w_done     = Rst && (w_state == S_ACCESS) && w_active && w_wait_hit;
        w_err      = w_done && (r_rd ? r_rd_err : w_oob);
        w_mem_we   = w_done && !r_rd && !w_oob;
        w_rd_ok    = w_done && r_rd && !r_rd_err;
        w_wait_inc = (w_state == S_ACCESS) && w_active && !w_wait_hit;
    end

    assign bus.PReady  = w_done;
    assign bus.PSlvErr = w_err;
    assign bus.PRData  = r_prdata;
    assign wr_count    = r_wr_count;
    assign rd_count    = r_rd_count;

    // Reads capture direction, address check and data in SETUP; writes use
    // the bus values present in the completing cycle.
    always_ff @(posedge clk) begin
        if (!Rst) begin
            r_wait     <= '0;
            r_rd       <= 1'b0;
            r_rd_err   <= 1'b0;
            r_prdata   <= '0;
            r_wr_count <= '0;
            r_rd_count <= '0;
        end else begin
            if (w_state == S_SETUP) begin
                r_wait   <= '0;
                r_rd     <= !bus.PWrite;
                r_rd_err <= w_oob;
                if (!bus.PWrite) r_prdata <= w_oob ? '0 : r_mem[w_idx];
            end else if (w_wait_inc) begin
                r_wait <= r_wait + 4'd1;
            end
            if (w_mem_we) r_wr_count <= r_wr_count + 16'd1;
            if (w_rd_ok)  r_rd_count <= r_rd_count + 16'd1;
        end
    end

    // Memory has no reset; w_mem_we already excludes reset cycles.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_idx] <= bus.PWData;
    end
endmodule
